cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 55 +++++
 rtl/cdb_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle of the Common Data Bus request/broadcast signals shared between the
// execution units (reservation stations) and the CDB arbiter.
//
//   Req                 : per-unit broadcast request (bit0 ADD1, bit1 ADD2,
//                         bit2 LOAD1, bit3 LOAD2)
//   Data_*              : result offered by each unit
//   R_target_*          : destination register of each unit's result
//   Cdb_hold            : suppresses new grants while high
//   Grant               : registered one-hot grant, same bit order as Req
//   CDB_valid           : CDB carries a result this cycle
//   CDB_tag             : producing reservation-station tag (0 when idle)
//   CDB_data            : broadcast result
//   CDB_R_target        : destination register of the broadcast result
//   Broadcast_count     : broadcasts since reset (wraps)
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int DATA_WIDTH = 16
);
    logic [3:0]            Req;
    logic [DATA_WIDTH-1:0] Data_ADD1;
    logic [DATA_WIDTH-1:0] Data_ADD2;
    logic [DATA_WIDTH-1:0] Data_LOAD1;
    logic [DATA_WIDTH-1:0] Data_LOAD2;
    logic [3:0]            R_target_ADD1;
    logic [3:0]            R_target_ADD2;
    logic [3:0]            R_target_LOAD1;
    logic [3:0]            R_target_LOAD2;
    logic                  Cdb_hold;
    logic [3:0]            Grant;
    logic                  CDB_valid;
    logic [2:0]            CDB_tag;
    logic [DATA_WIDTH-1:0] CDB_data;
    logic [3:0]            CDB_R_target;
    logic [15:0]           Broadcast_count;

    modport master (
        output Req,
        output Data_ADD1, Data_ADD2, Data_LOAD1, Data_LOAD2,
        output R_target_ADD1, R_target_ADD2, R_target_LOAD1, R_target_LOAD2,
        output Cdb_hold,
        input  Grant, CDB_valid, CDB_tag, CDB_data, CDB_R_target, Broadcast_count
    );

    modport slave (
        input  Req,
        input  Data_ADD1, Data_ADD2, Data_LOAD1, Data_LOAD2,
        input  R_target_ADD1, R_target_ADD2, R_target_LOAD1, R_target_LOAD2,
        input  Cdb_hold,
        output Grant, CDB_valid, CDB_tag, CDB_data, CDB_R_target, Broadcast_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the Common Data Bus of a Tomasulo-style core. Four
// units (ADD1, ADD2, LOAD1, LOAD2) request the bus; one winner per cycle has its
// result, destination register and tag broadcast with one cycle of latency.
//
// Ports:
//   Clock  : sole clock, all state updates on posedge
//   Reset  : synchronous, active-low reset
//   bus    : cdb_arbiter_if.slave (requests, unit results, hold, CDB outputs)
//
// A unit granted in the previous cycle is masked for one cycle so that a
// requester which is slow to drop Req is never broadcast twice.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int                    DATA_WIDTH        = 16,
    parameter logic [DATA_WIDTH-1:0] VALOR_SEM_VALOR   = 16'hFFF0,
    parameter logic [2:0]            FREE_REGISTER     = 3'd0,
    parameter logic [2:0]            RES_STATION_ADD1  = 3'd1,
    parameter logic [2:0]            RES_STATION_ADD2  = 3'd2,
    parameter logic [2:0]            RES_STATION_LOAD1 = 3'd3,
    parameter logic [2:0]            RES_STATION_LOAD2 = 3'd4
) (
    input  logic          Clock,
    input  logic          Reset,
    cdb_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;

    logic [1:0]            ptr_r;
    logic [3:0]            grant_r;
    logic [2:0]            tag_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [3:0]            rt_r;
    logic [15:0]           count_r;

    logic [3:0]            eligible_s;
    logic [1:0]            cand_s;
    logic                  win_found_s;
    logic [1:0]            win_idx_s;
    logic                  issue_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic [3:0]            win_rt_s;
    logic [2:0]            win_tag_s;
    logic [3:0]            win_onehot_s;

    // Round-robin search starting at ptr_r over requests not granted last cycle.
    always_comb begin
        eligible_s  = bus.Req & ~grant_r;
        win_found_s = 1'b0;
        win_idx_s   = ptr_r;
        cand_s      = ptr_r;
        for (int k = 0; k < 4; k++) begin
            cand_s = ptr_r + k[1:0];
            if (!win_found_s && eligible_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
        if (win_found_s && !bus.Cdb_hold) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Select the winning unit's payload, tag and grant bit.
    always_comb begin
        win_data_s   = VALOR_SEM_VALOR;
        win_rt_s     = 4'd0;
        win_tag_s    = FREE_REGISTER;
        win_onehot_s = 4'b0000;
        case (win_idx_s)
            2'd0: begin
                win_data_s   = bus.Data_ADD1;
                win_rt_s     = bus.R_target_ADD1;
                win_tag_s    = RES_STATION_ADD1;
                win_onehot_s = 4'b0001;
            end
            2'd1: begin
                win_data_s   = bus.Data_ADD2;
                win_rt_s     = bus.R_target_ADD2;
                win_tag_s    = RES_STATION_ADD2;
                win_onehot_s = 4'b0010;
            end
            2'd2: begin
                win_data_s   = bus.Data_LOAD1;
                win_rt_s     = bus.R_target_LOAD1;
                win_tag_s    = RES_STATION_LOAD1;
                win_onehot_s = 4'b0100;
            end
            2'd3: begin
                win_data_s   = bus.Data_LOAD2;
                win_rt_s     = bus.R_target_LOAD2;
                win_tag_s    = RES_STATION_LOAD2;
                win_onehot_s = 4'b1000;
            end
            default: begin
                win_data_s   = VALOR_SEM_VALOR;
                win_rt_s     = 4'd0;
                win_tag_s    = FREE_REGISTER;
                win_onehot_s = 4'b0000;
            end
        endcase
    end

    // FSM next state: any grant lands in BCAST, otherwise the bus goes idle.
    always_comb begin
        state_next_s = ST_IDLE;
        if (issue_s) begin
            state_next_s = ST_BCAST;
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered CDB payload, grant, round-robin pointer and broadcast counter.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            grant_r <= 4'b0000;
            tag_r   <= FREE_REGISTER;
            data_r  <= VALOR_SEM_VALOR;
            rt_r    <= 4'd0;
            ptr_r   <= 2'd0;
            count_r <= 16'd0;
        end else if (issue_s) begin
            grant_r <= win_onehot_s;
            tag_r   <= win_tag_s;
            data_r  <= win_data_s;
            rt_r    <= win_rt_s;
            ptr_r   <= win_idx_s + 2'd1;   // 3 wraps to 0 naturally
            count_r <= count_r + 16'd1;    // FFFF wraps to 0000
        end else begin
            grant_r <= 4'b0000;
            tag_r   <= FREE_REGISTER;
            data_r  <= VALOR_SEM_VALOR;
            rt_r    <= 4'd0;
        end
    end

    assign bus.Grant           = grant_r;
    assign bus.CDB_valid       = (state_r == ST_BCAST);
    assign bus.CDB_tag         = tag_r;
    assign bus.CDB_data        = data_r;
    assign bus.CDB_R_target    = rt_r;
    assign bus.Broadcast_count = count_r;

endmodule
